// File: rtl/fifo_status_pkg.sv
// Shared constants and elaboration helpers for the fifo_status buffer.
// Read-mode selectors for the FWFT parameter.
package fifo_status_pkg;

  localparam int FIFO_MODE_FWFT = 1;
  localparam int FIFO_MODE_REG  = 0;

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_status_flags.sv
// Occupancy flag decode for fifo_status.
// Every flag is a pure function of the registered count.
module fifo_status_flags #(
  parameter  int LENGTH        = 8,
  parameter  int AFULL_THRESH  = LENGTH - 1,
  parameter  int AEMPTY_THRESH = 1,
  localparam int CW            = $clog2(LENGTH) + 1
) (
  input  logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full
);

  assign empty        = (count == '0);
  assign full         = (count == CW'(LENGTH));
  assign almost_empty = (count <= CW'(AEMPTY_THRESH));
  assign almost_full  = (count >= CW'(AFULL_THRESH));

endmodule

// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy count, threshold flags, sticky error flags,
// synchronous flush and a selectable first-word-fall-through or registered read port.
module fifo_status
  import fifo_status_pkg::*;
#(
  parameter  int XLEN          = 32,
  parameter  int LENGTH        = 8,
  parameter  int AFULL_THRESH  = LENGTH - 1,
  parameter  int AEMPTY_THRESH = 1,
  parameter  int FWFT          = FIFO_MODE_FWFT,
  localparam int AW            = $clog2(LENGTH),
  localparam int CW            = AW + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            we,
  input  logic [XLEN-1:0] di,
  input  logic            re,
  input  logic            clrErr,
  output logic [XLEN-1:0] dout,
  output logic            empty,
  output logic            full,
  output logic            almostEmpty,
  output logic            almostFull,
  output logic [CW-1:0]   count,
  output logic            overflow,
  output logic            underflow
);

  if (!is_pow2(LENGTH) || LENGTH < 2) begin : g_bad_length
    $error("fifo_status: LENGTH=%0d must be a power of two >= 2", LENGTH);
  end
  if (AFULL_THRESH < 0 || AFULL_THRESH > LENGTH ||
      AEMPTY_THRESH < 0 || AEMPTY_THRESH > LENGTH) begin : g_bad_thresh
    $error("fifo_status: thresholds must lie in 0..%0d", LENGTH);
  end

  logic [XLEN-1:0] mem [LENGTH];
  logic [AW-1:0]   front_q, front_d;
  logic [AW-1:0]   back_q, back_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            w_acc, r_acc, mem_we;

  fifo_status_flags #(
    .LENGTH        (LENGTH),
    .AFULL_THRESH  (AFULL_THRESH),
    .AEMPTY_THRESH (AEMPTY_THRESH)
  ) u_flags (
    .count        (count_q),
    .empty        (empty),
    .full         (full),
    .almost_empty (almostEmpty),
    .almost_full  (almostFull)
  );

  // A full FIFO still accepts a write when the head is being read the same cycle.
  assign w_acc  = we & (~full | re);
  assign r_acc  = re & ~empty;
  assign mem_we = w_acc & ~flush;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    front_d     = front_q;
    back_d      = back_q;
    count_d     = count_q;
    overflow_d  = (overflow_q  & ~clrErr) | (~flush & we & ~w_acc);
    underflow_d = (underflow_q & ~clrErr) | (~flush & re & ~r_acc);
    if (flush) begin
      front_d = '0;
      back_d  = '0;
      count_d = '0;
    end else begin
      if (w_acc) back_d  = back_q + 1'b1;
      if (r_acc) front_d = front_q + 1'b1;
      if (w_acc && !r_acc)      count_d = count_q + 1'b1;
      else if (r_acc && !w_acc) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: state flops use non-blocking assignments so all of them see pre-edge values.
    if (!reset) begin
      front_q     <= '0;
      back_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      front_q     <= front_d;
      back_q      <= back_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which words are valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[back_q] <= di;
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign dout = mem[front_q];
  end else begin : g_reg
    logic [XLEN-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (r_acc && !flush) dout_d = mem[front_q];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) dout_q <= '0;
      else        dout_q <= dout_d;
    end

    assign dout = dout_q;
  end

  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_status.sv
// Self-checking bench for fifo_status: an FWFT and a registered-read instance share
// stimulus and are compared against a queue-based reference model.
module tb_fifo_status;

  localparam int XLEN   = 32;
  localparam int LENGTH = 4;
  localparam int AF     = 3;
  localparam int AE     = 1;
  localparam int CW     = 3;

  logic            clk = 1'b0;
  logic            reset, flush, we, re, clrErr;
  logic [XLEN-1:0] di;

  logic [XLEN-1:0] fw_dout, rg_dout;
  logic            fw_empty, fw_full, fw_ae, fw_af, fw_ovf, fw_unf;
  logic            rg_empty, rg_full, rg_ae, rg_af, rg_ovf, rg_unf;
  logic [CW-1:0]   fw_count, rg_count;

  wire [8:0] fw_status = {fw_empty, fw_full, fw_ae, fw_af, fw_ovf, fw_unf, fw_count};
  wire [8:0] rg_status = {rg_empty, rg_full, rg_ae, rg_af, rg_ovf, rg_unf, rg_count};

  fifo_status #(.XLEN(XLEN), .LENGTH(LENGTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(1))
  u_fwft (
    .clk(clk), .reset(reset), .flush(flush), .we(we), .di(di), .re(re), .clrErr(clrErr),
    .dout(fw_dout), .empty(fw_empty), .full(fw_full), .almostEmpty(fw_ae),
    .almostFull(fw_af), .count(fw_count), .overflow(fw_ovf), .underflow(fw_unf)
  );

  fifo_status #(.XLEN(XLEN), .LENGTH(LENGTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(0))
  u_reg (
    .clk(clk), .reset(reset), .flush(flush), .we(we), .di(di), .re(re), .clrErr(clrErr),
    .dout(rg_dout), .empty(rg_empty), .full(rg_full), .almostEmpty(rg_ae),
    .almostFull(rg_af), .count(rg_count), .overflow(rg_ovf), .underflow(rg_unf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents as a queue, sticky flags, last word read out.
  logic [XLEN-1:0] m_q[$];
  bit              m_ovf, m_unf;
  logic [XLEN-1:0] m_rdo;

  function automatic logic [8:0] exp_status();
    int n;
    n = m_q.size();
    return {n == 0, n == LENGTH, n <= AE, n >= AF, m_ovf, m_unf, 3'(n)};
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_rdo = '0;
  endtask

  task automatic model_edge();
    int n;
    bit wacc, racc;
    n = m_q.size();
    if (clrErr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (flush) begin
      m_q.delete();
      return;
    end
    wacc = we && (n < LENGTH || re);
    racc = re && (n > 0);
    if (we && !wacc) m_ovf = 1;
    if (re && !racc) m_unf = 1;
    if (racc) m_rdo = m_q.pop_front();
    if (wacc) m_q.push_back(di);
  endtask

  // Drive one cycle of inputs, step the model at the edge, return #1 after it.
  task automatic cycle(input logic w, input logic [XLEN-1:0] d, input logic r,
                       input logic f, input logic c);
    we = w; di = d; re = r; flush = f; clrErr = c;
    @(posedge clk);
    model_edge();
    #1;
    we = 0; re = 0; flush = 0; clrErr = 0;
  endtask

  task automatic apply_reset();
    reset = 0;
    model_reset();
    #3;
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    we = 0; re = 0; flush = 0; clrErr = 0; di = '0;
    reset = 0;
    model_reset();
    #12;
    checks++;
    if (fw_status !== 9'b1_0_1_0_0_0_000) begin
      errors++; $display("FAIL reset_status fwft got %b exp %b", fw_status, 9'b101000000);
    end
    checks++;
    if (rg_dout !== 32'h0) begin
      errors++; $display("FAIL reset_dout reg got %h exp 00000000", rg_dout);
    end
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_underflow();
    cycle(0, '0, 1, 0, 0);
    checks++;
    if (fw_empty !== 1'b1 || fw_count !== 3'd0 || fw_unf !== 1'b1 || u_fwft.front_q !== 2'd0) begin
      errors++;
      $display("FAIL underflow got empty=%b count=%0d unf=%b front=%0d exp 1 0 1 0",
               fw_empty, fw_count, fw_unf, u_fwft.front_q);
    end
    cycle(0, '0, 0, 0, 1);
    checks++;
    if (fw_unf !== 1'b0 || rg_unf !== 1'b0) begin
      errors++; $display("FAIL clr_err got unf=%b/%b exp 0", fw_unf, rg_unf);
    end
  endtask

  task automatic test_fill();
    logic [XLEN-1:0] words [4];
    words = '{32'hdeadbeef, 32'hbababebe, 32'hcacacaca, 32'hfeedbeef};
    for (int i = 0; i < 4; i++) begin
      cycle(1, words[i], 0, 0, 0);
      checks++;
      if (fw_count !== 3'(i + 1) || fw_af !== (i >= 2) || fw_full !== (i == 3)) begin
        errors++;
        $display("FAIL fill_%0d got count=%0d af=%b full=%b exp %0d %b %b",
                 i, fw_count, fw_af, fw_full, i + 1, i >= 2, i == 3);
      end
    end
    cycle(1, 32'h0, 0, 0, 0);
    checks++;
    if (fw_ovf !== 1'b1 || fw_count !== 3'd4 || u_fwft.back_q !== 2'd0) begin
      errors++;
      $display("FAIL overflow got ovf=%b count=%0d back=%0d exp 1 4 0",
               fw_ovf, fw_count, u_fwft.back_q);
    end
    checks++;
    if (rg_status !== exp_status()) begin
      errors++; $display("FAIL overflow_reg_status got %b exp %b", rg_status, exp_status());
    end
  endtask

  task automatic test_full_rw();
    logic [XLEN-1:0] expect_rd [4];
    expect_rd = '{32'hbababebe, 32'hcacacaca, 32'hfeedbeef, 32'h01010101};
    checks++;
    if (fw_dout !== 32'hdeadbeef) begin
      errors++; $display("FAIL fwft_head got %h exp deadbeef", fw_dout);
    end
    cycle(1, 32'h01010101, 1, 0, 1);
    checks++;
    if (fw_full !== 1'b1 || fw_count !== 3'd4 || rg_dout !== 32'hdeadbeef || fw_ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_rw got full=%b count=%0d rdo=%h ovf=%b exp 1 4 deadbeef 0",
               fw_full, fw_count, rg_dout, fw_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fw_dout !== expect_rd[i]) begin
        errors++; $display("FAIL fwft_read_%0d got %h exp %h", i, fw_dout, expect_rd[i]);
      end
      cycle(0, '0, 1, 0, 0);
      checks++;
      if (rg_dout !== expect_rd[i]) begin
        errors++; $display("FAIL reg_read_%0d got %h exp %h", i, rg_dout, expect_rd[i]);
      end
    end
    checks++;
    if (fw_empty !== 1'b1 || fw_status !== exp_status()) begin
      errors++; $display("FAIL drained got %b exp %b", fw_status, exp_status());
    end
  endtask

  task automatic test_registered_read();
    apply_reset();
    cycle(1, 32'haaaa0001, 0, 0, 0);
    cycle(1, 32'haaaa0002, 0, 0, 0);
    we = 0; re = 1;
    #2;
    checks++;
    if (rg_dout !== 32'h0) begin
      errors++; $display("FAIL reg_before_edge got %h exp 00000000", rg_dout);
    end
    cycle(0, '0, 1, 0, 0);
    checks++;
    if (rg_dout !== 32'haaaa0001) begin
      errors++; $display("FAIL reg_after_edge got %h exp aaaa0001", rg_dout);
    end
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    checks++;
    if (rg_dout !== 32'haaaa0001 || fw_dout !== 32'haaaa0002) begin
      errors++; $display("FAIL reg_hold got %h/%h exp aaaa0001/aaaa0002", rg_dout, fw_dout);
    end
  endtask

  task automatic test_flush();
    cycle(1, 32'hb0000001, 0, 0, 0);
    cycle(1, 32'hb0000002, 0, 0, 0);
    checks++;
    if (fw_count !== 3'd3) begin
      errors++; $display("FAIL pre_flush_count got %0d exp 3", fw_count);
    end
    cycle(1, 32'h12345678, 0, 1, 0);
    checks++;
    if (fw_count !== 3'd0 || fw_empty !== 1'b1 || fw_ovf !== 1'b0 || rg_dout !== 32'haaaa0001) begin
      errors++;
      $display("FAIL flush got count=%0d empty=%b ovf=%b rdo=%h exp 0 1 0 aaaa0001",
               fw_count, fw_empty, fw_ovf, rg_dout);
    end
    cycle(1, 32'h5555aaaa, 0, 0, 0);
    checks++;
    if (fw_dout !== 32'h5555aaaa) begin
      errors++; $display("FAIL post_flush_fwft got %h exp 5555aaaa", fw_dout);
    end
    cycle(0, '0, 1, 0, 0);
    checks++;
    if (rg_dout !== 32'h5555aaaa || fw_empty !== 1'b1) begin
      errors++; $display("FAIL post_flush_reg got %h empty=%b exp 5555aaaa 1", rg_dout, fw_empty);
    end
  endtask

  task automatic test_wrap();
    logic [XLEN-1:0] sent [$];
    logic [XLEN-1:0] word;
    sent.delete();
    word = 32'hc0de0000;
    cycle(1, word, 0, 0, 0);
    sent.push_back(word);
    for (int i = 1; i <= 10; i++) begin
      word = 32'hc0de0000 + 32'(i);
      cycle(1, word, 1, 0, 0);
      sent.push_back(word);
      checks++;
      if (rg_dout !== sent[0] || fw_count !== 3'd1 || fw_dout !== word) begin
        errors++;
        $display("FAIL wrap_%0d got rdo=%h count=%0d fwdo=%h exp %h 1 %h",
                 i, rg_dout, fw_count, fw_dout, sent[0], word);
      end
      void'(sent.pop_front());
      if (i == 6) begin
        #2;
        reset = 0;
        model_reset();
        #1;
        checks++;
        if (fw_count !== 3'd0 || fw_empty !== 1'b1 || rg_count !== 3'd0 || rg_dout !== 32'h0) begin
          errors++;
          $display("FAIL async_reset got count=%0d empty=%b rdo=%h exp 0 1 00000000",
                   fw_count, fw_empty, rg_dout);
        end
        #3;
        reset = 1;
        @(posedge clk);
        #1;
        sent.delete();
        word = 32'hc0de0100;
        cycle(1, word, 0, 0, 0);
        sent.push_back(word);
      end
    end
  endtask

  task automatic test_random();
    logic w, r, f, c;
    int bias;
    for (int i = 0; i < 600; i++) begin
      bias = (i / 50) % 3;
      w = ($urandom_range(0, 9) < (bias == 0 ? 8 : (bias == 1 ? 2 : 5)));
      r = ($urandom_range(0, 9) < (bias == 0 ? 2 : (bias == 1 ? 8 : 5)));
      f = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 19) == 0);
      cycle(w, $urandom, r, f, c);
      checks++;
      if (fw_status !== exp_status() || rg_status !== exp_status()) begin
        errors++;
        $display("FAIL rand_status_%0d got %b/%b exp %b", i, fw_status, rg_status, exp_status());
      end
      checks++;
      if (rg_dout !== m_rdo) begin
        errors++; $display("FAIL rand_reg_dout_%0d got %h exp %h", i, rg_dout, m_rdo);
      end
      if (m_q.size() > 0) begin
        checks++;
        if (fw_dout !== m_q[0]) begin
          errors++; $display("FAIL rand_fwft_dout_%0d got %h exp %h", i, fw_dout, m_q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_fill();
    test_full_rw();
    test_registered_read();
    test_flush();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_status.md
Name: fifo_status

Overview:
Parametrised synchronous FIFO, the successor of the basic fifo primitive. Adds the following over that primitive:
- selectable read mode: first-word-fall-through or registered output
- occupancy count
- programmable almost-full and almost-empty flags
- sticky overflow/underflow error flags
- synchronous flush

Sits in rtl/primitives and serves as the buffer for UART/peripheral RX/TX paths and bus-bridge queues.

Parameters:
XLEN, 32, data width in bits (>=1)
LENGTH, 8, depth in entries; power of two, >=2
AFULL_THRESH, LENGTH-1, almostFull asserted when count >= AFULL_THRESH
AEMPTY_THRESH, 1, almostEmpty asserted when count <= AEMPTY_THRESH
FWFT, 1, 1 = first-word-fall-through (do shows the head combinationally); 0 = registered read (do updates one cycle after accepted re)

Ports:
clk  in  1  clock, all state changes on rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of contents and pointers
we  in  1  write request
di  in  XLEN  write data
re  in  1  read request
clrErr  in  1  synchronous clear of overflow/underflow
do  out  XLEN  read data
empty  out  1  count == 0
full  out  1  count == LENGTH
almostEmpty  out  1  count <= AEMPTY_THRESH
almostFull  out  1  count >= AFULL_THRESH
count  out  $clog2(LENGTH)+1  current occupancy
overflow  out  1  sticky: write rejected because full
underflow  out  1  sticky: read rejected because empty

Behaviour:
- Storage: LENGTH x XLEN register array. frontPointer and backPointer are $clog2(LENGTH) bits, wrapping naturally modulo LENGTH. A separate count register distinguishes full from empty.
- Reset (reset low, async), all outputs and state:
  - pointers = 0, count = 0
  - empty = 1, full = 0, almostEmpty = 1, almostFull = (AFULL_THRESH == 0)
  - overflow = 0, underflow = 0, registered do = 0
  - memory contents are not reset
- Acceptance, evaluated on the count at the clock edge:
  - wAcc = we & (~full | re)
  - rAcc = re & ~empty
- Accepted write: mem[backPointer] <= di; backPointer++.
- Accepted read: frontPointer++.
- count: +1 on wAcc only; -1 on rAcc only; unchanged when both or neither.
- Full with we & re: both accepted. The head is read, the new word is written into the freed slot, and full stays 1.
- Empty with we & re: write accepted, read rejected. count becomes 1 and underflow is set.
- Write rejected when full (we & ~re): overflow <= 1; pointers and memory unchanged.
- Read rejected when empty: underflow <= 1; pointers unchanged.
- clrErr clears both sticky flags. If an error occurs in the same cycle as clrErr, the flag ends set (set wins).
- flush:
  - pointers and count go to 0; registered do holds its value; sticky flags are unaffected.
  - flush has priority over we/re in the same cycle: the write is dropped and no error is flagged.
- FWFT=1: do = mem[frontPointer] combinationally; zero read latency. do is undefined (don't-care) while empty.
- FWFT=0: on rAcc, do <= mem[frontPointer] at the edge, so data is valid the cycle after re. Otherwise do holds its value.
- Status flags are derived from the count register (registered state), so they update in the cycle after the causing edge and never combinationally from we/re.
- Parameter legality is checked at elaboration with an initial $error:
  - LENGTH must be a power of two
  - thresholds must lie in 0..LENGTH

Decomposition:
- Add to rtl/constants.vh: FIFO read-mode constants (FIFO_MODE_FWFT = 1, FIFO_MODE_REG = 0).
- No shared typedefs.
- One natural sub-module: fifo_status_flags, the combinational flag/threshold decode from count (empty, full, almostEmpty, almostFull). Everything else lives in fifo_status.

Test Plan (LENGTH=4, XLEN=32, AFULL_THRESH=3, AEMPTY_THRESH=1 unless stated):
1. Reset, then re for one cycle while empty
   -> empty=1, count=0, frontPointer=0, underflow=1. Then clrErr one cycle -> underflow=0.
2. Write deadbeef, bababebe, cacacaca, feedbeef, then one more write of 00000000
   -> count steps 1,2,3,4; almostFull=1 at count 3; full=1 at 4.
   -> Fifth write: overflow=1, backPointer stays 0, count stays 4.
3. FWFT=1, full from scenario 2, re&we with di=01010101
   -> full stays 1, do=deadbeef before the edge.
   -> Subsequent reads return bababebe, cacacaca, feedbeef, 01010101, then empty=1.
4. FWFT=0, write aaaa0001 and aaaa0002, then re for one cycle
   -> do=0 until the edge, do=aaaa0001 the cycle after, and do holds aaaa0001 while re is low.
5. Three entries stored, assert flush together with we (di=12345678)
   -> next cycle count=0, empty=1, no overflow. A following write + read returns the post-flush data only.
6. Pointer wrap: issue 10 write/read pairs interleaved, one in flight
   -> data returned in order across the wrap, count never exceeds 1.
   -> Assert reset low mid-sequence (asynchronously, off-edge) -> count=0, empty=1 immediately, before the next edge.
